alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Shares the single combinational `alu` between two requesters: the core execute path on port 0 and an auxiliary address/compare requester on port 1. Each request carries an opcode, func3, func7 and two operands. The block arbitrates round-robin, drives the ALU from registered operands for one execute cycle, and captures `data_out`, `zero` and `comparision`. It returns the captured result to the granted requester over a valid/ready response channel.

## Interface
- WIDTH, 32, operand/result width; must match the instantiated `alu`.

Ports (N ∈ {0,1}; every `reqN_*`/`rspN_*` line exists for both ports):
- clk  in  1  single clock, rising edge
- rst  in  1  reset; asynchronous, active-high
- reqN_valid  in  1  request N presents an operation
- reqN_ready  out  1  request N accepted this cycle when valid&ready
- reqN_opcode  in  7  RISC-V opcode
- reqN_func3  in  3  func3
- reqN_func7  in  7  func7
- reqN_a  in  WIDTH  operand 1
- reqN_b  in  WIDTH  operand 2
- rspN_valid  out  1  result for requester N is available
- rspN_ready  in  1  requester N consumes the result
- rspN_data  out  WIDTH  captured ALU `data_out`
- rspN_zero  out  1  captured ALU `zero`
- rspN_cmp  out  1  captured ALU `comparision`
- alu_opcode / alu_func3 / alu_func7  out  7/3/7  registered controls to the ALU
- alu_a / alu_b  out  WIDTH  registered operands to the ALU
- alu_data_out  in  WIDTH  ALU result
- alu_zero  in  1  ALU zero flag
- alu_cmp  in  1  ALU comparison flag
- busy  out  1  high when the state is not IDLE

## Operation
- FSM states: IDLE, EXEC, RESP.
- **IDLE**
  - Arbitrate the valid requests. If only one is valid, it wins. If both are valid, the one not granted last wins.
  - `reqN_ready` is high only for the winner, and only in IDLE. It is combinational from the valids and `last_grant`.
  - On a handshake: latch opcode, func3, func7, a and b into the `alu_*` registers; set `gnt`=N; update `last_grant`=N; go to EXEC.
- **EXEC**
  - The ALU sees stable registered inputs for the whole cycle.
  - At the cycle end, capture `alu_data_out`, `alu_zero` and `alu_cmp` into the result registers, then go to RESP.
- **RESP**
  - `rsp[gnt]_valid`=1. The other port's `rsp_valid` stays 0.
  - Result outputs hold stable until `rsp[gnt]_ready`=1. On that cycle, clear valid and return to IDLE.
- In every state other than EXEC, the `alu_*` registers are held at 0 (opcode 0 drives the ALU default, `data_out`=0).
- `rspN_data`, `rspN_zero` and `rspN_cmp` show the capture registers on both ports. Only `rspN_valid` qualifies them.
- No operation decoding or checking: unsupported opcodes pass through, and the response carries whatever the ALU produced.
- `comparision` is meaningful only for branch opcodes. It is captured unconditionally.

## Timing
- Reset values: state=IDLE; `last_grant`=1, so port 0 wins first; all `rspN_valid`=0; all capture registers=0; all `alu_*`=0; `busy`=0; `reqN_ready` follows the IDLE arbitration.
- Latency: handshake at edge T → EXEC during cycle T+1 → `rspN_valid`=1 in cycle T+2.
- Throughput: at most one operation per 3 cycles when the response is consumed immediately.
- Backpressure:
  - While in RESP with ready low, no request is accepted on either port (both `reqN_ready`=0).
  - A request must keep its valid and payload stable until accepted.
- Simultaneous events:
  - Response consumed at edge T: the state is IDLE in T+1, and a new handshake is possible in T+1, not T.
  - Both ports valid on consecutive grants: they alternate 0,1,0,1.
- Reset mid-operation (EXEC or RESP): the operation is dropped with no response. After release, the state is IDLE and `last_grant`=1.

## Structure
- Shared package `alu_pkg`:
  - Opcode constants: ALI_OP=7'b0010011, AL_OP=7'b0110011, MEM_WR_OP=7'b0100011, MEM_RD_OP=7'b0000011, BR_OP=7'b1100011, JALR=7'b1100111, LUI=7'b0110111.
  - `arb_state_t` enum {IDLE, EXEC, RESP}.
  - `alu_req_t` struct {opcode, func3, func7, a, b}.
- One sub-module: `rr_arbiter2`. Inputs: two valids, `last_grant`. Outputs: one-hot grant. Purely combinational.

## Test plan
- Port 0: ADD (opcode 0110011, func3 000, func7 0), a=5, b=7; `rsp0_ready`=1 → `rsp0_valid` 2 cycles after the handshake, `rsp0_data`=12, `rsp0_zero`=0; `rsp1_valid` stays 0.
- Port 1: SUB (func7 0100000), a=3, b=3 → `rsp1_data`=0, `rsp1_zero`=1.
- Both ports valid right after reset (port 0 BEQ a=9, b=9; port 1 ADDI a=1, b=2) → port 0 served first with `rsp0_cmp`=1, then port 1 with `rsp1_data`=3; grant order 0,1.
- Backpressure: `rsp0_ready` low for 3 cycles → `rsp0_data`, `rsp0_zero` and `rsp0_cmp` stable; `req1_ready`=0 throughout; port 1 accepted in the first IDLE cycle after consumption.
- Assert `rst` during EXEC → immediately `busy`=0, all `rsp_valid`=0, `alu_*`=0; no response appears after release; the next request is granted normally.
- Sustained valids on both ports for 12 cycles with `rsp_ready` tied high → 4 operations complete, strictly alternating ports, one every 3 cycles.

Source files
------------

// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU arbiter slice: RISC-V opcode constants, the
// arbiter state encoding and the request record that is latched into the ALU
// operand registers.
// Ports: none (package).
// -----------------------------------------------------------------------------
package alu_pkg;

  // Width of the shared ALU datapath; the request record is sized from it.
  localparam int ALU_WIDTH = 32;

  // RISC-V opcodes understood by the shared ALU.
  localparam logic [6:0] ALI_OP    = 7'b0010011;
  localparam logic [6:0] AL_OP     = 7'b0110011;
  localparam logic [6:0] MEM_WR_OP = 7'b0100011;
  localparam logic [6:0] MEM_RD_OP = 7'b0000011;
  localparam logic [6:0] BR_OP     = 7'b1100011;
  localparam logic [6:0] JALR      = 7'b1100111;
  localparam logic [6:0] LUI       = 7'b0110111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic [6:0]           opcode;
    logic [2:0]           func3;
    logic [6:0]           func7;
    logic [ALU_WIDTH-1:0] a;
    logic [ALU_WIDTH-1:0] b;
  } alu_req_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// -----------------------------------------------------------------------------
// alu_arbiter_if
// One requester's view of the ALU arbiter: a valid/ready request channel that
// carries opcode, func3, func7 and two operands, plus a valid/ready response
// channel that returns the captured ALU result, zero flag and compare flag.
// Modports:
//   master - requester side (drives request payload and rsp_ready)
//   slave  - arbiter side (drives req_ready and the response payload)
// -----------------------------------------------------------------------------
interface alu_arbiter_if
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) ();

  logic             req_valid;
  logic             req_ready;
  logic [6:0]       req_opcode;
  logic [2:0]       req_func3;
  logic [6:0]       req_func7;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_zero;
  logic             rsp_cmp;

  modport master (
    output req_valid, req_opcode, req_func3, req_func7, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_zero, rsp_cmp
  );

  modport slave (
    input  req_valid, req_opcode, req_func3, req_func7, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_zero, rsp_cmp
  );

endinterface

// File: rtl/alu_arbiter_rr.sv
// -----------------------------------------------------------------------------
// rr_arbiter2
// Two-way round-robin arbiter, purely combinational.
// Ports:
//   i_valid0, i_valid1 - requests from port 0 and port 1
//   i_lastGrant        - port that won the previous arbitration
//   o_grant            - one-hot grant, bit N set when port N wins
// -----------------------------------------------------------------------------
module rr_arbiter2 (
  input  logic       i_valid0,
  input  logic       i_valid1,
  input  logic       i_lastGrant,
  output logic [1:0] o_grant
);

  // A lone request always wins; when both ask, the port that was not served
  // last time goes next so neither side can starve the other.
  always_comb begin
    o_grant = 2'b00;
    if (i_valid0 && i_valid1) begin
      o_grant = i_lastGrant ? 2'b01 : 2'b10;
    end else if (i_valid0) begin
      o_grant = 2'b01;
    end else if (i_valid1) begin
      o_grant = 2'b10;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
// Shares one combinational ALU between the core execute path (port 0) and an
// auxiliary address/compare requester (port 1). A request is accepted in IDLE,
// its fields drive the ALU from registers for one EXEC cycle, the ALU outputs
// are captured, and the result is offered back to the granted port in RESP
// until that port takes it.
// Ports:
//   clk, rst                     - clock (rising edge), async active-high reset
//   port0, port1                 - requester channels (alu_arbiter_if.slave)
//   alu_opcode/func3/func7/a/b   - registered controls and operands to the ALU
//   alu_data_out/zero/cmp        - ALU result, zero flag, comparison flag
//   busy                         - high whenever the arbiter is not in IDLE
// -----------------------------------------------------------------------------
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  alu_arbiter_if.slave     port0,
  alu_arbiter_if.slave     port1,
  output logic [6:0]       alu_opcode,
  output logic [2:0]       alu_func3,
  output logic [6:0]       alu_func7,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_data_out,
  input  logic             alu_zero,
  input  logic             alu_cmp,
  output logic             busy
);

  arb_state_t       r_state;
  arb_state_t       w_nextState;
  logic             r_lastGrant;
  logic             r_gnt;
  alu_req_t         r_aluReq;
  alu_req_t         w_req0;
  alu_req_t         w_req1;
  logic [WIDTH-1:0] r_resData;
  logic             r_resZero;
  logic             r_resCmp;
  logic [1:0]       w_grant;
  logic             w_inIdle;
  logic             w_hs0;
  logic             w_hs1;
  logic             w_rspReady;

  rr_arbiter2 u_arb (
    .i_valid0    (port0.req_valid),
    .i_valid1    (port1.req_valid),
    .i_lastGrant (r_lastGrant),
    .o_grant     (w_grant)
  );

  assign w_inIdle = (r_state == IDLE);

  // Only the arbitration winner sees ready, and only while idle, so nothing
  // can be accepted while a result is still waiting to be collected.
  assign port0.req_ready = w_inIdle & w_grant[0];
  assign port1.req_ready = w_inIdle & w_grant[1];
  assign w_hs0 = port0.req_valid & port0.req_ready;
  assign w_hs1 = port1.req_valid & port1.req_ready;

  // The response handshake that matters is the one on the granted port.
  assign w_rspReady = r_gnt ? port1.rsp_ready : port0.rsp_ready;

  // Gather each port's payload into a request record so either one can be
  // latched into the operand registers with a single assignment.
  always_comb begin
    w_req0        = '0;
    w_req0.opcode = port0.req_opcode;
    w_req0.func3  = port0.req_func3;
    w_req0.func7  = port0.req_func7;
    w_req0.a      = port0.req_a;
    w_req0.b      = port0.req_b;
    w_req1        = '0;
    w_req1.opcode = port1.req_opcode;
    w_req1.func3  = port1.req_func3;
    w_req1.func7  = port1.req_func7;
    w_req1.a      = port1.req_a;
    w_req1.b      = port1.req_b;
  end

  // State register. Reset drops any operation in flight without a response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic: one cycle of execution, then hold the result until the
  // granted requester consumes it.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (w_hs0 || w_hs1) begin
          w_nextState = EXEC;
        end
      end
      EXEC: begin
        w_nextState = RESP;
      end
      RESP: begin
        if (w_rspReady) begin
          w_nextState = IDLE;
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Datapath registers. The ALU operand registers are only non-zero during
  // EXEC: they load on the accepting edge and clear on the capturing edge,
  // so outside EXEC the ALU sees opcode 0 and produces its default result.
  // last_grant resets to 1 so that port 0 wins the first contested round.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_aluReq    <= '0;
      r_gnt       <= 1'b0;
      r_lastGrant <= 1'b1;
      r_resData   <= '0;
      r_resZero   <= 1'b0;
      r_resCmp    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_hs0) begin
            r_aluReq    <= w_req0;
            r_gnt       <= 1'b0;
            r_lastGrant <= 1'b0;
          end else if (w_hs1) begin
            r_aluReq    <= w_req1;
            r_gnt       <= 1'b1;
            r_lastGrant <= 1'b1;
          end
        end
        EXEC: begin
          r_resData <= alu_data_out;
          r_resZero <= alu_zero;
          r_resCmp  <= alu_cmp;
          r_aluReq  <= '0;
        end
        default: begin
        end
      endcase
    end
  end

  assign alu_opcode = r_aluReq.opcode;
  assign alu_func3  = r_aluReq.func3;
  assign alu_func7  = r_aluReq.func7;
  assign alu_a      = r_aluReq.a;
  assign alu_b      = r_aluReq.b;

  // Both ports see the same capture registers; rsp_valid alone says whose
  // result it is.
  assign port0.rsp_valid = (r_state == RESP) & ~r_gnt;
  assign port1.rsp_valid = (r_state == RESP) &  r_gnt;
  assign port0.rsp_data  = r_resData;
  assign port1.rsp_data  = r_resData;
  assign port0.rsp_zero  = r_resZero;
  assign port1.rsp_zero  = r_resZero;
  assign port0.rsp_cmp   = r_resCmp;
  assign port1.rsp_cmp   = r_resCmp;

  assign busy = ~w_inIdle;

endmodule

// File: tb/tb_alu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_arbiter
// Bench for alu_arbiter. A behavioural ALU answers the registered ALU controls
// combinationally. Each request pushes its expected result to a scoreboard in
// the order it should be served; a negedge monitor pops and compares whenever
// a response is consumed and logs the cycle and port of each response.
// -----------------------------------------------------------------------------
module tb_alu_arbiter;
  import alu_pkg::*;

  typedef struct packed {
    logic [31:0] data;
    logic        zero;
    logic        cmp;
  } aluRes_t;

  typedef struct {
    int          port;
    logic [31:0] data;
    logic        zero;
    logic        cmp;
  } exp_t;

  typedef struct {
    int cyc;
    int port;
  } log_t;

  logic        clk;
  logic        rst;
  logic [6:0]  alu_opcode;
  logic [2:0]  alu_func3;
  logic [6:0]  alu_func7;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_data_out;
  logic        alu_zero;
  logic        alu_cmp;
  logic        busy;
  aluRes_t     aluNow;

  int       total = 0;
  int       bad = 0;
  int       cyc = 0;
  bit       acc0 = 0;
  bit       acc1 = 0;
  exp_t     expQ[$];
  log_t     rspLog[$];
  alu_req_t pend0[$];
  alu_req_t pend1[$];

  alu_arbiter_if #(.WIDTH(32)) if0 ();
  alu_arbiter_if #(.WIDTH(32)) if1 ();

  alu_arbiter #(.WIDTH(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .port0        (if0),
    .port1        (if1),
    .alu_opcode   (alu_opcode),
    .alu_func3    (alu_func3),
    .alu_func7    (alu_func7),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_data_out (alu_data_out),
    .alu_zero     (alu_zero),
    .alu_cmp      (alu_cmp),
    .busy         (busy)
  );

  // Free-running 100 MHz clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle counter used to time responses.
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural ALU: a small subset of RV32I, enough for the stimulus used.
  function automatic aluRes_t refAlu(input logic [6:0] op, input logic [2:0] f3,
                                     input logic [6:0] f7, input logic [31:0] a,
                                     input logic [31:0] b);
    aluRes_t r;
    r.data = 32'd0;
    r.cmp  = 1'b0;
    case (op)
      AL_OP, ALI_OP: begin
        case (f3)
          3'b000:  r.data = (op == AL_OP && f7[5]) ? a - b : a + b;
          3'b100:  r.data = a ^ b;
          3'b110:  r.data = a | b;
          3'b111:  r.data = a & b;
          default: r.data = 32'd0;
        endcase
      end
      BR_OP: begin
        r.data = a - b;
        case (f3)
          3'b000:  r.cmp = (a == b);
          3'b001:  r.cmp = (a != b);
          3'b100:  r.cmp = ($signed(a) < $signed(b));
          3'b101:  r.cmp = ($signed(a) >= $signed(b));
          default: r.cmp = 1'b0;
        endcase
      end
      LUI:     r.data = b;
      default: r.data = 32'd0;
    endcase
    r.zero = (r.data == 32'd0);
    return r;
  endfunction

  // The ALU the arbiter drives lives in the bench.
  always_comb aluNow = refAlu(alu_opcode, alu_func3, alu_func7, alu_a, alu_b);
  assign alu_data_out = aluNow.data;
  assign alu_zero     = aluNow.zero;
  assign alu_cmp      = aluNow.cmp;

  function automatic alu_req_t mkReq(input logic [6:0] op, input logic [2:0] f3,
                                     input logic [6:0] f7, input logic [31:0] a,
                                     input logic [31:0] b);
    alu_req_t r;
    r.opcode = op;
    r.func3  = f3;
    r.func7  = f7;
    r.a      = a;
    r.b      = b;
    return r;
  endfunction

  function automatic logic rspValidOf(input int port);
    return (port == 0) ? if0.rsp_valid : if1.rsp_valid;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  task automatic present(input int port, input alu_req_t r);
    if (port == 0) begin
      if0.req_valid = 1'b1; if0.req_opcode = r.opcode; if0.req_func3 = r.func3;
      if0.req_func7 = r.func7; if0.req_a = r.a; if0.req_b = r.b;
    end else begin
      if1.req_valid = 1'b1; if1.req_opcode = r.opcode; if1.req_func3 = r.func3;
      if1.req_func7 = r.func7; if1.req_a = r.a; if1.req_b = r.b;
    end
  endtask

  // Queue a request on a port and record the result it should produce. Calls
  // must be made in the order the arbiter is expected to serve them.
  task automatic applyStimulus(input int port, input alu_req_t r);
    aluRes_t res;
    exp_t    e;
    res    = refAlu(r.opcode, r.func3, r.func7, r.a, r.b);
    e.port = port;
    e.data = res.data;
    e.zero = res.zero;
    e.cmp  = res.cmp;
    expQ.push_back(e);
    if (port == 0) begin
      pend0.push_back(r);
      if (!if0.req_valid) present(0, r);
    end else begin
      pend1.push_back(r);
      if (!if1.req_valid) present(1, r);
    end
  endtask

  // Advance to just after the next rising edge and retire any request that
  // was accepted on it, presenting the port's next pending request if any.
  task automatic nextCycle();
    @(posedge clk);
    #1;
    if (acc0) begin
      void'(pend0.pop_front());
      if (pend0.size() > 0) present(0, pend0[0]);
      else if0.req_valid = 1'b0;
    end
    if (acc1) begin
      void'(pend1.pop_front());
      if (pend1.size() > 0) present(1, pend1[0]);
      else if1.req_valid = 1'b0;
    end
  endtask

  task automatic doReset();
    rst = 1'b1;
    expQ.delete();
    pend0.delete();
    pend1.delete();
    if0.req_valid = 1'b0;
    if1.req_valid = 1'b0;
    nextCycle();
    nextCycle();
    rst = 1'b0;
  endtask

  // Step until the given port shows a response (bounded); returns at the
  // negedge where it is seen so the caller can inspect it.
  task automatic waitRsp(input int port, input int budget, input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (rspValidOf(port)) seen = 1'b1;
      else nextCycle();
    end
    checkOutput({tag, "_seen"}, 64'(seen), 64'd1);
  endtask

  // One isolated operation with cycle-exact checks against fixed results.
  task automatic directedOp(input int port, input alu_req_t r, input logic [31:0] expData,
                            input logic expZero, input string tag);
    applyStimulus(port, r);
    @(negedge clk);
    checkOutput({tag, "_reqReady"}, 64'(port == 0 ? if0.req_ready : if1.req_ready), 64'd1);
    checkOutput({tag, "_otherReady"}, 64'(port == 0 ? if1.req_ready : if0.req_ready), 64'd0);
    nextCycle();
    @(negedge clk);
    checkOutput({tag, "_execBusy"}, 64'(busy), 64'd1);
    checkOutput({tag, "_aluOpcode"}, 64'(alu_opcode), 64'(r.opcode));
    checkOutput({tag, "_aluA"}, 64'(alu_a), 64'(r.a));
    checkOutput({tag, "_aluB"}, 64'(alu_b), 64'(r.b));
    checkOutput({tag, "_earlyValid"}, 64'(rspValidOf(port)), 64'd0);
    nextCycle();
    @(negedge clk);
    checkOutput({tag, "_rspValid"}, 64'(rspValidOf(port)), 64'd1);
    checkOutput({tag, "_otherRspValid"}, 64'(rspValidOf(1 - port)), 64'd0);
    checkOutput({tag, "_data"}, 64'(port == 0 ? if0.rsp_data : if1.rsp_data), 64'(expData));
    checkOutput({tag, "_zero"}, 64'(port == 0 ? if0.rsp_zero : if1.rsp_zero), 64'(expZero));
    nextCycle();
    @(negedge clk);
    checkOutput({tag, "_idleAgain"}, 64'(busy), 64'd0);
  endtask

  // Monitor: note request handshakes for the drivers, and compare every
  // consumed response against the head of the scoreboard.
  always @(negedge clk) begin : monitor
    int   rspPort;
    logic consumed;
    exp_t e;
    log_t l;
    acc0 = !rst && if0.req_valid && if0.req_ready;
    acc1 = !rst && if1.req_valid && if1.req_ready;
    if (!rst && (if0.rsp_valid || if1.rsp_valid)) begin
      checkOutput("rspOneHot", 64'(if0.rsp_valid & if1.rsp_valid), 64'd0);
      rspPort  = if1.rsp_valid ? 1 : 0;
      consumed = (rspPort == 1) ? if1.rsp_ready : if0.rsp_ready;
      if (consumed) begin
        checkOutput("sbHasEntry", 64'(expQ.size() != 0), 64'd1);
        if (expQ.size() != 0) begin
          e = expQ.pop_front();
          checkOutput("sbPort", 64'(rspPort), 64'(e.port));
          checkOutput("sbData", 64'(rspPort == 1 ? if1.rsp_data : if0.rsp_data), 64'(e.data));
          checkOutput("sbZero", 64'(rspPort == 1 ? if1.rsp_zero : if0.rsp_zero), 64'(e.zero));
          checkOutput("sbCmp", 64'(rspPort == 1 ? if1.rsp_cmp : if0.rsp_cmp), 64'(e.cmp));
          l.cyc  = cyc;
          l.port = rspPort;
          rspLog.push_back(l);
        end
      end
    end
  end

  // Safety net in case the design wedges somewhere unexpected.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: time limit reached, got no finish, want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main sequence.
  initial begin
    int       startCyc;
    int       s;
    alu_req_t r;
    rst = 1'b1;
    if0.req_valid = 1'b0; if0.req_opcode = '0; if0.req_func3 = '0; if0.req_func7 = '0;
    if0.req_a = '0; if0.req_b = '0; if0.rsp_ready = 1'b0;
    if1.req_valid = 1'b0; if1.req_opcode = '0; if1.req_func3 = '0; if1.req_func7 = '0;
    if1.req_a = '0; if1.req_b = '0; if1.rsp_ready = 1'b0;

    // Reset state.
    nextCycle();
    @(negedge clk);
    checkOutput("rstBusy", 64'(busy), 64'd0);
    checkOutput("rstRsp0Valid", 64'(if0.rsp_valid), 64'd0);
    checkOutput("rstRsp1Valid", 64'(if1.rsp_valid), 64'd0);
    checkOutput("rstAluOpcode", 64'(alu_opcode), 64'd0);
    checkOutput("rstRspData", 64'(if0.rsp_data), 64'd0);
    nextCycle();
    rst = 1'b0;
    @(negedge clk);
    checkOutput("postRstBusy", 64'(busy), 64'd0);
    nextCycle();

    // Port 0 ADD 5+7, port 1 SUB 3-3.
    $display("[TB] directed ADD on port 0 and SUB on port 1");
    if0.rsp_ready = 1'b1;
    directedOp(0, mkReq(AL_OP, 3'b000, 7'b0000000, 32'd5, 32'd7), 32'd12, 1'b0, "t1add");
    nextCycle();
    if1.rsp_ready = 1'b1;
    directedOp(1, mkReq(AL_OP, 3'b000, 7'b0100000, 32'd3, 32'd3), 32'd0, 1'b1, "t2sub");
    nextCycle();

    // Both ports valid straight after reset: port 0 first.
    $display("[TB] contested grant after reset");
    doReset();
    applyStimulus(0, mkReq(BR_OP, 3'b000, 7'b0000000, 32'd9, 32'd9));
    applyStimulus(1, mkReq(ALI_OP, 3'b000, 7'b0000000, 32'd1, 32'd2));
    @(negedge clk);
    checkOutput("t3Req0Ready", 64'(if0.req_ready), 64'd1);
    checkOutput("t3Req1Ready", 64'(if1.req_ready), 64'd0);
    nextCycle();
    waitRsp(0, 10, "t3p0");
    checkOutput("t3Cmp", 64'(if0.rsp_cmp), 64'd1);
    nextCycle();
    waitRsp(1, 10, "t3p1");
    checkOutput("t3Data", 64'(if1.rsp_data), 64'd3);
    nextCycle();

    // Backpressure on port 0 while port 1 waits.
    $display("[TB] response backpressure");
    if0.rsp_ready = 1'b0;
    applyStimulus(0, mkReq(AL_OP, 3'b000, 7'b0000000, 32'd100, 32'd23));
    applyStimulus(1, mkReq(ALI_OP, 3'b100, 7'b0000000, 32'h0F0, 32'h03C));
    @(negedge clk);
    checkOutput("t4Req0Ready", 64'(if0.req_ready), 64'd1);
    nextCycle();
    nextCycle();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput("t4HoldValid", 64'(if0.rsp_valid), 64'd1);
      checkOutput("t4HoldData", 64'(if0.rsp_data), 64'd123);
      checkOutput("t4HoldZero", 64'(if0.rsp_zero), 64'd0);
      checkOutput("t4HoldCmp", 64'(if0.rsp_cmp), 64'd0);
      checkOutput("t4Req1Blocked", 64'(if1.req_ready), 64'd0);
      nextCycle();
    end
    if0.rsp_ready = 1'b1;
    @(negedge clk);
    checkOutput("t4StillValid", 64'(if0.rsp_valid), 64'd1);
    nextCycle();
    @(negedge clk);
    checkOutput("t4IdleBusy", 64'(busy), 64'd0);
    checkOutput("t4Req1Ready", 64'(if1.req_ready), 64'd1);
    nextCycle();
    @(negedge clk);
    checkOutput("t4P1Exec", 64'(alu_b), 64'h03C);
    waitRsp(1, 10, "t4p1");
    checkOutput("t4P1Data", 64'(if1.rsp_data), 64'h0CC);
    nextCycle();

    // Reset while executing: operation dropped, arbiter usable afterwards.
    $display("[TB] reset during EXEC");
    applyStimulus(0, mkReq(AL_OP, 3'b000, 7'b0000000, 32'd10, 32'd20));
    @(negedge clk);
    checkOutput("t5Req0Ready", 64'(if0.req_ready), 64'd1);
    nextCycle();
    checkOutput("t5InExec", 64'(busy), 64'd1);
    rst = 1'b1;
    #1;
    checkOutput("t5RstBusy", 64'(busy), 64'd0);
    checkOutput("t5RstRsp0", 64'(if0.rsp_valid), 64'd0);
    checkOutput("t5RstRsp1", 64'(if1.rsp_valid), 64'd0);
    checkOutput("t5RstOpcode", 64'(alu_opcode), 64'd0);
    checkOutput("t5RstA", 64'(alu_a), 64'd0);
    checkOutput("t5RstB", 64'(alu_b), 64'd0);
    doReset();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checkOutput("t5NoRsp", 64'(if0.rsp_valid), 64'd0);
      checkOutput("t5Idle", 64'(busy), 64'd0);
      nextCycle();
    end
    applyStimulus(0, mkReq(AL_OP, 3'b000, 7'b0000000, 32'd2, 32'd3));
    applyStimulus(1, mkReq(AL_OP, 3'b000, 7'b0100000, 32'd9, 32'd4));
    @(negedge clk);
    checkOutput("t5Req0Ready", 64'(if0.req_ready), 64'd1);
    checkOutput("t5Req1Ready", 64'(if1.req_ready), 64'd0);
    nextCycle();
    waitRsp(0, 10, "t5p0");
    checkOutput("t5P0Data", 64'(if0.rsp_data), 64'd5);
    nextCycle();
    waitRsp(1, 10, "t5p1");
    checkOutput("t5P1Data", 64'(if1.rsp_data), 64'd5);
    nextCycle();

    // Sustained traffic on both ports; port 1 went last so port 0 leads.
    $display("[TB] sustained alternating traffic");
    startCyc = cyc;
    s = rspLog.size();
    for (int i = 0; i < 6; i++) begin
      case (i)
        0:       r = mkReq(AL_OP, 3'b000, 7'b0000000, $urandom, $urandom);
        1:       r = mkReq(AL_OP, 3'b000, 7'b0100000, $urandom, $urandom);
        2:       r = mkReq(ALI_OP, 3'b100, 7'b0000000, $urandom, $urandom);
        3:       r = mkReq(BR_OP, 3'b001, 7'b0000000, $urandom, $urandom);
        4:       r = mkReq(AL_OP, 3'b111, 7'b0000000, $urandom, $urandom);
        default: r = mkReq(BR_OP, 3'b100, 7'b0000000, $urandom, $urandom);
      endcase
      applyStimulus(i % 2, r);
    end
    for (int k = 0; k < 40; k++) begin
      if (expQ.size() == 0) break;
      nextCycle();
    end
    checkOutput("t6Drained", 64'(expQ.size()), 64'd0);
    checkOutput("t6Count", 64'(rspLog.size() - s), 64'd6);
    for (int i = 0; i < 6; i++) begin
      if (s + i < rspLog.size()) begin
        checkOutput("t6Port", 64'(rspLog[s + i].port), 64'(i % 2));
        checkOutput("t6Cycle", 64'(rspLog[s + i].cyc - startCyc), 64'(2 + 3 * i));
      end
    end
    nextCycle();

    checkOutput("sbEmpty", 64'(expQ.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
